i2c_slave_regfile: RTL and testbench
====================================

# i2c_slave_regfile

I2C target (responder) that lets an external I2C master read and write an 8-bit-data register space. It is the far end of our I2C configuration masters: it decodes START/STOP, the 7-bit device address, a 1- or 2-byte register address and data bytes. It turns them into single-cycle register-port strobes with auto-increment. It sits behind the SCL/SDA pad pair, with a register bank or CSR block on its register port.

## Interface
- `DEV_ADDR`, default 7'h3c: 7-bit device address this target answers to.
- `clk` input 1: system clock. Must be at least 20× the SCL frequency.
- `rst` input 1: synchronous, active-high reset.
- `i2c_addr_2byte` input 1: 1 means the register address is 2 bytes (MSB first); 0 means 1 byte.
- `scl_pad_i` input 1: SCL line. Input only; this block never stretches SCL.
- `sda_pad_i` input 1: SDA line input.
- `sda_pad_o` output 1: SDA output value. Constant 1'b0.
- `sda_padoen_o` output 1: SDA output enable, active low. 0 pulls SDA low.
- `reg_addr` output 16: current register pointer.
- `reg_wr` output 1: one-clk write strobe.
- `reg_wdata` output 8: write data. Valid while `reg_wr` is high.
- `reg_rd` output 1: one-clk read strobe for `reg_addr`.
- `reg_rdata` input 8: read data. Sampled on the clk after `reg_rd`.
- `busy` output 1: high from an addressed START until STOP, NACK-out or address mismatch.

## Operation
- **Input conditioning.** SCL and SDA pass through a 2-flop synchronizer (plus the optional filter). Previous-sample registers give these events:
  - `scl_rise` and `scl_fall`.
  - START: SCL high on both samples and SDA falling.
  - STOP: SCL high on both samples and SDA rising.
- **START / STOP override.** START (including a repeated START) from any state goes to DEV, clears the bit counter and releases SDA. STOP from any state goes to IDLE, releases SDA and clears `busy`.
- **States.** IDLE, DEV, DEV_ACK, REG_H, REG_L, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT.
- **Bit timing.** Bits are shifted in MSB first on `scl_rise`. SDA drive changes only on `scl_fall`.
- **DEV.** After 8 bits, compare `byte[7:1]` with `DEV_ADDR`.
  - Match: latch R/W, set `busy`, go to DEV_ACK.
  - Mismatch: go to WAIT, never driving SDA.
- **ACK states.** On the `scl_fall` that ends bit 8, drive `sda_padoen_o` = 0. On the next `scl_fall`, release it, or drive the first read bit. Then go to the next state:
  - DEV_ACK, write: REG_H if `i2c_addr_2byte`, else REG_L.
  - DEV_ACK, read: RD_DATA.
  - REG_ACK after REG_H: REG_L.
  - REG_ACK after REG_L: WR_DATA.
- **Register address.**
  - REG_H loads `reg_addr[15:8]`.
  - REG_L loads `reg_addr[7:0]`.
  - In 1-byte mode, REG_L also clears `reg_addr[15:8]`.
- **WR_DATA.** On the 8th `scl_rise`, assert `reg_wr` for one clk with the current `reg_addr` and `reg_wdata` = received byte. Increment `reg_addr` on the following clk, then go to WR_ACK, which acks as above and returns to WR_DATA.
- **Read fetch.** On the `scl_rise` of the ACK bit that precedes a read byte, assert `reg_rd` for one clk. This is the ACK of DEV_ACK, or a master ACK sampled low in RD_ACK. Capture `reg_rdata` into the TX shifter on the next clk.
- **RD_DATA.** Each `scl_fall` drives `sda_padoen_o` = the current bit. A 1 releases the line; a 0 pulls it low (open-drain). After bit 8, release SDA, increment `reg_addr` and go to RD_ACK.
- **RD_ACK.** Sample SDA on `scl_rise`.
  - Low (ACK): fetch the next byte and return to RD_DATA.
  - High (NACK): go to WAIT and clear `busy`.
- **WAIT.** SDA released; only START or STOP leaves this state.
- **Pointer wrap.**
  - 2-byte mode: 16'hffff goes to 16'h0000.
  - 1-byte mode: 8'hff goes to 8'h00, with the upper byte held at 0.

## Timing
- Reset values: `sda_pad_o` 0, `sda_padoen_o` 1, `reg_addr` 0, `reg_wr` 0, `reg_wdata` 0, `reg_rd` 0, `busy` 0, state IDLE.
- Pin-to-event latency: 3 clk without the filter, 7 clk with it.
- `reg_wr` and `reg_rd` are exactly one clk wide. They are never high together, and there is at most one strobe per byte.
- The register port must return `reg_rdata` one clk after `reg_rd` (registered read).
- Reset mid-transfer: SDA is released on the next clk and all state is discarded.
- START arriving mid-byte aborts that byte. No strobe is issued for a partial byte.

## Configuration
- `I2C_SLAVE_FILTER_EN`
  - Defined: each synchronized line passes a stability filter. The filtered value changes only after the input has been stable for 4 consecutive clk, which rejects glitches of 3 clk or less.
  - Undefined: 2-flop synchronizer only.

## Test plan
- **1-byte write.** `i2c_addr_2byte`=0; START, 0x78, 0x12, 0xA5, 0x5A, STOP → ACK on all 4 bytes; `reg_wr` (0x0012, 0xA5) then (0x0013, 0x5A); `busy` low after STOP.
- **2-byte write.** `i2c_addr_2byte`=1; START, 0x78, 0x30, 0x08, 0x42, STOP → single `reg_wr` (0x3008, 0x42).
- **Read with repeated START.** Write pointer 0x20, repeated START, 0x79, master ACK, then NACK; model `reg_rdata` = ~addr[7:0] → SDA carries 0xDF then 0xDE; two `reg_rd` pulses; SDA released after the NACK.
- **Address mismatch.** START, 0xA0, 0x12, 0x34, STOP → no ACK (`sda_padoen_o` stays 1), no strobes, `busy` stays 0.
- **Pointer wrap.** 1-byte mode; reg 0xFF, write 2 bytes → `reg_wr` at 0x00FF then 0x0000.
- **Reset and filter.**
  - `rst` asserted while ACK is pulling SDA low → `sda_padoen_o`=1 on the next clk, and the following transaction completes normally.
  - With `I2C_SLAVE_FILTER_EN`, a 2-clk SCL low glitch mid-byte → no bit shift and the byte completes correctly.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target that turns bus transactions into strobed 8-bit register-port accesses
// Ports: clk/rst system clock and synchronous reset; scl_pad_i/sda_pad_i bus lines; sda_pad_o/sda_padoen_o
// open-drain SDA driver (oen low pulls the line); i2c_addr_2byte selects 1- or 2-byte register addresses;
// reg_addr/reg_wr/reg_wdata/reg_rd/reg_rdata register port; busy marks an addressed transaction.
// Define I2C_SLAVE_FILTER_EN to add a 4-clk stability filter behind the synchronizers.
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h3c
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_addr_2byte,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
  output logic        sda_pad_o,
  output logic        sda_padoen_o,
  output logic [15:0] reg_addr,
  output logic        reg_wr,
  output logic [7:0]  reg_wdata,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);
  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, REG_H, REG_L, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT
  } state_t;
  state_t      state_q;
  logic [1:0]  scl_sq, sda_sq;
  logic        scl_s, sda_s, scl_p_q, sda_p_q;
  logic        rise, fall, start, stop;
  logic [3:0]  cnt_q;
  logic [6:0]  shift_q;
  logic [7:0]  tx_q, rx, wdata_q;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, hi_q, ph_q, oen_q, busy_q, wr_q, rd_q, inc_q, ld_q;
  always_ff @(posedge clk)
    if (rst) begin
      scl_sq <= 2'b11;
      sda_sq <= 2'b11;
    end else begin
      scl_sq <= {scl_sq[0], scl_pad_i};
      sda_sq <= {sda_sq[0], sda_pad_i};
    end
`ifdef I2C_SLAVE_FILTER_EN
  logic       scl_f_q, sda_f_q;
  logic [1:0] scl_c_q, sda_c_q;
  // the filtered value follows only after 4 consecutive clk of disagreement
  always_ff @(posedge clk)
    if (rst) begin
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
      scl_c_q <= 2'd0;
      sda_c_q <= 2'd0;
    end else begin
      scl_c_q <= (scl_sq[1] == scl_f_q) ? 2'd0 : scl_c_q + 2'd1;
      sda_c_q <= (sda_sq[1] == sda_f_q) ? 2'd0 : sda_c_q + 2'd1;
      if (scl_sq[1] != scl_f_q && scl_c_q == 2'd3) scl_f_q <= scl_sq[1];
      if (sda_sq[1] != sda_f_q && sda_c_q == 2'd3) sda_f_q <= sda_sq[1];
    end
  assign scl_s = scl_f_q;
  assign sda_s = sda_f_q;
`else
  assign scl_s = scl_sq[1];
  assign sda_s = sda_sq[1];
`endif
  always_ff @(posedge clk)
    if (rst) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_s;
      sda_p_q <= sda_s;
    end
  assign rise   = scl_s & ~scl_p_q;
  assign fall   = ~scl_s & scl_p_q;
  assign start  = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop   = scl_s & scl_p_q & ~sda_p_q & sda_s;
  assign rx     = {shift_q, sda_s};
  assign addr_d = i2c_addr_2byte ? addr_q + 16'd1 : {8'h00, addr_q[7:0] + 8'd1};
  // ph_q: in ACK states, set once our ACK is on the bus; in RD_ACK, set once the master has ACKed
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      shift_q <= 7'd0;
      tx_q    <= 8'hff;
      rw_q    <= 1'b0;
      hi_q    <= 1'b0;
      ph_q    <= 1'b0;
      oen_q   <= 1'b1;
      busy_q  <= 1'b0;
      addr_q  <= 16'd0;
      wr_q    <= 1'b0;
      wdata_q <= 8'd0;
      rd_q    <= 1'b0;
      inc_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      inc_q <= 1'b0;
      ld_q  <= rd_q;
      if (inc_q) addr_q <= addr_d;
      if (ld_q) tx_q <= reg_rdata;
      if (stop) begin
        state_q <= IDLE;
        oen_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else if (start) begin
        state_q <= DEV;
        cnt_q   <= 4'd0;
        oen_q   <= 1'b1;
        ph_q    <= 1'b0;
      end else case (state_q)
        DEV, REG_H, REG_L, WR_DATA: if (rise) begin
          shift_q <= rx[6:0];
          cnt_q   <= (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            ph_q <= 1'b0;
            if (state_q == DEV) begin
              rw_q    <= rx[0];
              busy_q  <= rx[7:1] == DEV_ADDR;
              state_q <= (rx[7:1] == DEV_ADDR) ? DEV_ACK : WAIT;
            end else if (state_q == REG_H) begin
              addr_q[15:8] <= rx;
              hi_q         <= 1'b1;
              state_q      <= REG_ACK;
            end else if (state_q == REG_L) begin
              addr_q  <= {i2c_addr_2byte ? addr_q[15:8] : 8'h00, rx};
              hi_q    <= 1'b0;
              state_q <= REG_ACK;
            end else begin
              wr_q    <= 1'b1;
              wdata_q <= rx;
              inc_q   <= 1'b1;
              state_q <= WR_ACK;
            end
          end
        end
        DEV_ACK, REG_ACK, WR_ACK: begin
          if (rise && ph_q && state_q == DEV_ACK && rw_q) rd_q <= 1'b1;
          if (fall && !ph_q) begin
            oen_q <= 1'b0;
            ph_q  <= 1'b1;
          end else if (fall) begin
            ph_q <= 1'b0;
            if (state_q == DEV_ACK && rw_q) begin
              oen_q   <= tx_q[7];
              tx_q    <= {tx_q[6:0], 1'b1};
              cnt_q   <= 4'd1;
              state_q <= RD_DATA;
            end else begin
              oen_q   <= 1'b1;
              state_q <= (state_q == DEV_ACK) ? (i2c_addr_2byte ? REG_H : REG_L) :
                         (state_q == REG_ACK && hi_q) ? REG_L : WR_DATA;
            end
          end
        end
        RD_DATA: if (fall) begin
          if (cnt_q == 4'd8) begin
            oen_q   <= 1'b1;
            inc_q   <= 1'b1;
            cnt_q   <= 4'd0;
            ph_q    <= 1'b0;
            state_q <= RD_ACK;
          end else begin
            oen_q <= tx_q[7];
            tx_q  <= {tx_q[6:0], 1'b1};
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RD_ACK: if (rise && !sda_s) begin
          rd_q <= 1'b1;
          ph_q <= 1'b1;
        end else if (rise) begin
          busy_q  <= 1'b0;
          state_q <= WAIT;
        end else if (fall && ph_q) begin
          ph_q    <= 1'b0;
          oen_q   <= tx_q[7];
          tx_q    <= {tx_q[6:0], 1'b1};
          cnt_q   <= 4'd1;
          state_q <= RD_DATA;
        end
        default: oen_q <= 1'b1;
      endcase
    end
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign reg_addr     = addr_q;
  assign reg_wr       = wr_q;
  assign reg_wdata    = wdata_q;
  assign reg_rd       = rd_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C master with table-driven write vectors and a strobe scoreboard
module tb_i2c_slave_regfile;
  localparam int Q = 8;
  logic        clk = 1'b0, rst = 1'b1, a2 = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic        sda_bus, sda_pad_o, sda_padoen_o, reg_wr, reg_rd, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  rdata_q = 8'h00;
  int          n_chk = 0, n_pass = 0;
  i2c_slave_regfile dut (
    .clk(clk), .rst(rst), .i2c_addr_2byte(a2), .scl_pad_i(scl_m), .sda_pad_i(sda_bus),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rd(reg_rd), .reg_rdata(rdata_q), .busy(busy)
  );
  always #5 clk = ~clk;
  assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);
  always @(posedge clk) if (reg_rd) rdata_q <= ~reg_addr[7:0];
  logic [23:0] obs_wr [256];
  logic [15:0] obs_rd [256];
  logic [7:0]  obs_wn = 0, obs_rn = 0;
  int          drv_cnt = 0, busy_cnt = 0, bad_cnt = 0;
  logic        wr_p = 1'b0, rd_p = 1'b0;
  always @(negedge clk) begin
    if (reg_wr) begin
      obs_wr[obs_wn] <= {reg_addr, reg_wdata};
      obs_wn <= obs_wn + 8'd1;
    end
    if (reg_rd) begin
      obs_rd[obs_rn] <= reg_addr;
      obs_rn <= obs_rn + 8'd1;
    end
    if (!sda_padoen_o) drv_cnt <= drv_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if ((reg_wr && reg_rd) || (reg_wr && wr_p) || (reg_rd && rd_p)) bad_cnt <= bad_cnt + 1;
    wr_p <= reg_wr;
    rd_p <= reg_rd;
  end
  typedef struct {
    logic        a2;
    logic [7:0]  dev;
    logic [15:0] ra;
    int          nd;
    logic [7:0]  d0, d1;
    logic        ack;
    logic [15:0] wa0, wa1;
    logic        g;
  } vec_t;
  vec_t        vecs[$];
  logic [23:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  wr_ptr = 0, rd_ptr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start;
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask
  task automatic i2c_stop;
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask
  task automatic wr_byte(input logic [7:0] b, input logic glitch, input logic do_rst, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wq(Q);
      scl_m = 1'b1;
      if (glitch && i == 3) begin
        wq(Q); scl_m = 1'b0; wq(2); scl_m = 1'b1; wq(Q - 2);
      end else wq(2 * Q);
      scl_m = 1'b0; wq(Q);
    end
    sda_m = 1'b1; wq(Q);
    if (do_rst) begin
      chk("ack_before_rst", sda_padoen_o, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_release_sda", sda_padoen_o, 1'b1);
      chk("rst_busy", busy, 1'b0);
      wq(2);
      rst = 1'b0;
    end
    scl_m = 1'b1; wq(Q);
    ack = !sda_bus; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask
  task automatic rd_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      b[i] = sda_bus; wq(Q);
      scl_m = 1'b0; wq(Q);
    end
    sda_m = !mack; wq(Q);
    scl_m = 1'b1; wq(2 * Q);
    scl_m = 1'b0; wq(Q);
    sda_m = 1'b1;
  endtask
  task automatic drain;
    logic [23:0] ew;
    logic [15:0] er;
    while (exp_wr.size() != 0) begin
      ew = exp_wr.pop_front();
      if (wr_ptr < obs_wn) chk("wr_strobe", obs_wr[wr_ptr], ew);
      else chk("wr_strobe_missing", obs_wn, wr_ptr + 8'd1);
      wr_ptr++;
    end
    while (exp_rd.size() != 0) begin
      er = exp_rd.pop_front();
      if (rd_ptr < obs_rn) chk("rd_strobe", obs_rd[rd_ptr], er);
      else chk("rd_strobe_missing", obs_rn, rd_ptr + 8'd1);
      rd_ptr++;
    end
    chk("wr_strobe_count", obs_wn, wr_ptr);
    chk("rd_strobe_count", obs_rn, rd_ptr);
    wr_ptr = obs_wn;
    rd_ptr = obs_rn;
  endtask
  task automatic run_vec(input vec_t v);
    int   d0, b0;
    logic a;
    a2 = v.a2;
    if (v.ack) begin
      exp_wr.push_back({v.wa0, v.d0});
      if (v.nd > 1) exp_wr.push_back({v.wa1, v.d1});
    end
    d0 = drv_cnt;
    b0 = busy_cnt;
    i2c_start;
    wr_byte(v.dev, v.g, 1'b0, a); chk("dev_ack", a, v.ack);
    if (v.a2) begin
      wr_byte(v.ra[15:8], v.g, 1'b0, a); chk("regh_ack", a, v.ack);
    end
    wr_byte(v.ra[7:0], v.g, 1'b0, a); chk("regl_ack", a, v.ack);
    wr_byte(v.d0, v.g, 1'b0, a); chk("data0_ack", a, v.ack);
    if (v.nd > 1) begin
      wr_byte(v.d1, v.g, 1'b0, a); chk("data1_ack", a, v.ack);
    end
    i2c_stop;
    wq(20);
    chk("busy_after_stop", busy, 1'b0);
    chk("sda_driven", drv_cnt != d0, v.ack);
    chk("busy_seen", busy_cnt != b0, v.ack);
    drain();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic       a;
    logic [7:0] b;
    vecs.push_back('{1'b0, 8'h78, 16'h0012, 2, 8'hA5, 8'h5A, 1'b1, 16'h0012, 16'h0013, 1'b0});
    vecs.push_back('{1'b1, 8'h78, 16'h3008, 1, 8'h42, 8'h00, 1'b1, 16'h3008, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 8'hA0, 16'h0012, 1, 8'h34, 8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 8'h78, 16'h00FF, 2, 8'h11, 8'h22, 1'b1, 16'h00FF, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 8'h78, 16'hFFFF, 2, 8'h33, 8'h44, 1'b1, 16'hFFFF, 16'h0000, 1'b0});
`ifdef I2C_SLAVE_FILTER_EN
    vecs.push_back('{1'b0, 8'h78, 16'h0050, 1, 8'hC3, 8'h00, 1'b1, 16'h0050, 16'h0000, 1'b1});
`endif
    wq(5);
    chk("rst_sda_padoen_o", sda_padoen_o, 1'b1);
    chk("rst_sda_pad_o", sda_pad_o, 1'b0);
    chk("rst_reg_addr", reg_addr, 16'h0000);
    chk("rst_reg_wr", reg_wr, 1'b0);
    chk("rst_reg_wdata", reg_wdata, 8'h00);
    chk("rst_reg_rd", reg_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    wq(10);
    foreach (vecs[i]) run_vec(vecs[i]);
    a2 = 1'b0;
    i2c_start;
    wr_byte(8'h78, 1'b0, 1'b0, a); chk("rd_dev_w_ack", a, 1'b1);
    wr_byte(8'h20, 1'b0, 1'b0, a); chk("rd_ptr_ack", a, 1'b1);
    exp_rd.push_back(16'h0020);
    exp_rd.push_back(16'h0021);
    i2c_start;
    wr_byte(8'h79, 1'b0, 1'b0, a); chk("rd_dev_r_ack", a, 1'b1);
    rd_byte(1'b1, b); chk("rd_byte0", b, 8'hDF);
    rd_byte(1'b0, b); chk("rd_byte1", b, 8'hDE);
    wq(10);
    chk("rd_nack_release", sda_padoen_o, 1'b1);
    chk("rd_nack_busy", busy, 1'b0);
    chk("rd_ptr_after", reg_addr, 16'h0022);
    i2c_stop;
    wq(20);
    drain();
    i2c_start;
    wr_byte(8'h78, 1'b0, 1'b1, a);
    i2c_stop;
    wq(20);
    chk("post_rst_addr", reg_addr, 16'h0000);
    run_vec('{1'b0, 8'h78, 16'h0040, 1, 8'h99, 8'h00, 1'b1, 16'h0040, 16'h0000, 1'b0});
    chk("strobe_rules", bad_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
